// File: rtl/pipeline_sequencer.sv
// Central sequencer for the 5-stage pipeline: start/freeze, load-use bubbles,
// branch flushes, debug single-step and post-HALT drain.
module pipeline_sequencer #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      step_mode_i,
  input  logic                      step_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt_i,
  input  logic                      ex_mem_read_i,
  input  logic                      mem_branch_taken_i,
  input  logic                      id_halt_i,
  output logic                      stage_en_o,
  output logic                      pc_write_o,
  output logic                      if_id_write_o,
  output logic                      nop_flag_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_flush_o,
  output logic                      running_o,
  output logic                      halted_o,
  output logic [COUNT_WIDTH-1:0]    cycle_count_o
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP_HOLD,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [COUNT_WIDTH-1:0] cycle_count_q;
  logic                 load_use;
  logic                 advance;

  // Register zero is never a real dependency, so a load to $0 never stalls.
  assign load_use = ex_mem_read_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      if (stage_en_o) begin
        cycle_count_q <= cycle_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign cycle_count_o = cycle_count_q;

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    advance        = 1'b0;
    stage_en_o     = 1'b0;
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    nop_flag_o     = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    running_o      = 1'b0;
    halted_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = step_mode_i ? S_STEP_HOLD : S_RUN;
        end
      end
      S_RUN: begin
        running_o = 1'b1;
        advance   = 1'b1;
        if (step_mode_i) begin
          state_d = S_STEP_HOLD;
        end
      end
      S_STEP_HOLD: begin
        running_o = 1'b1;
        if (step_i) begin
          advance = 1'b1;
        end else if (!step_mode_i) begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        running_o  = 1'b1;
        stage_en_o = 1'b1;
        // A taken branch during drain means the HALT was fetched down the wrong path.
        if (mem_branch_taken_i) begin
          pc_write_o     = 1'b1;
          if_id_write_o  = 1'b1;
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
          ex_mem_flush_o = 1'b1;
          drain_cnt_d    = '0;
          state_d        = S_RUN;
        end else begin
          nop_flag_o  = 1'b1;
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
          if (drain_cnt_q == DRAIN_W'(1)) begin
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        halted_o = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Advance cycle: branch flush beats load-use stall beats halt.
    if (advance) begin
      stage_en_o    = 1'b1;
      pc_write_o    = 1'b1;
      if_id_write_o = 1'b1;
      if (mem_branch_taken_i) begin
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
      end else if (load_use) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        nop_flag_o    = 1'b1;
      end else if (id_halt_i) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        nop_flag_o    = 1'b1;
        drain_cnt_d   = DRAIN_W'(DRAIN_CYCLES);
        state_d       = S_DRAIN;
      end
    end

    // Reset silences every control output so no flush or enable leaks out.
    if (!rst_n) begin
      stage_en_o     = 1'b0;
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      nop_flag_o     = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      running_o      = 1'b0;
      halted_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: per-cycle stimulus with expected
// control vector and cycle count queued on drive, popped and compared at negedge.
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, step_mode, step, ex_mem_read, br_taken, halt;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       stage_en, pc_write, if_id_write, nop_flag;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, running, halted;
  logic [31:0] cycle_count;

  pipeline_sequencer #(
    .REG_ADDR_WIDTH(5),
    .COUNT_WIDTH   (32),
    .DRAIN_CYCLES  (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start),
    .step_mode_i       (step_mode),
    .step_i            (step),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .ex_rt_i           (ex_rt),
    .ex_mem_read_i     (ex_mem_read),
    .mem_branch_taken_i(br_taken),
    .id_halt_i         (halt),
    .stage_en_o        (stage_en),
    .pc_write_o        (pc_write),
    .if_id_write_o     (if_id_write),
    .nop_flag_o        (nop_flag),
    .if_id_flush_o     (if_id_flush),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_flush_o    (ex_mem_flush),
    .running_o         (running),
    .halted_o          (halted),
    .cycle_count_o     (cycle_count)
  );

  // {stage_en, pc_write, if_id_write, nop, if_id_fl, id_ex_fl, ex_mem_fl, running, halted}
  wire [8:0] obs = {stage_en, pc_write, if_id_write, nop_flag,
                    if_id_flush, id_ex_flush, ex_mem_flush, running, halted};

  localparam logic [8:0] C_IDLE  = 9'b000000000;
  localparam logic [8:0] C_RUN   = 9'b111000010;
  localparam logic [8:0] C_STALL = 9'b100100010;
  localparam logic [8:0] C_BR    = 9'b111011110;
  localparam logic [8:0] C_HOLD  = 9'b000000010;
  localparam logic [8:0] C_HALT  = 9'b000000001;

  typedef struct packed {
    logic       rst, st, sm, sp;
    logic [4:0] rs, rt, ert;
    logic       mr, br, hl;
    logic [8:0] ctl;
  } stim_t;

  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;

  function automatic stim_t mk(input logic rst, input logic st, input logic sm,
                               input logic sp, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] ert,
                               input logic mr, input logic b, input logic hl,
                               input logic [8:0] ctl);
    mk = '{rst, st, sm, sp, rs, rt, ert, mr, b, hl, ctl};
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show this cycle.
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst_n       = s.rst;
    start       = s.st;
    step_mode   = s.sm;
    step        = s.sp;
    id_rs       = s.rs;
    id_rt       = s.rt;
    ex_rt       = s.ert;
    ex_mem_read = s.mr;
    br_taken    = s.br;
    halt        = s.hl;
    sb.push_back('{ctl: s.ctl, cnt: exp_cnt});
    if (!s.rst)        exp_cnt = '0;
    else if (s.ctl[8]) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_reset();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    t.push_back(mk(1, 0, 1, 1, 5, 5, 5, 1, 1, 1, C_IDLE));
    t.push_back(mk(1, 0, 0, 0, 5, 5, 5, 1, 1, 1, C_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL reset[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_run();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    repeat (4) t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL run[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 0, 0, 0, 0, 5, 5, 1, 0, 0, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 0, 5, 5, 0, 0, 0, C_RUN));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RUN));
    t.push_back(mk(1, 0, 0, 0, 7, 1, 7, 1, 0, 0, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 4, 6, 3, 1, 0, 0, C_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL load_use[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 0, 0, 0, 0, 5, 5, 1, 1, 0, C_BR));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_BR));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL branch[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_STALL));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 0, 5, 5, 1, 0, 0, C_STALL));
    t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, C_HALT));
    t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_HALT));
    t.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, C_HALT));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL halt[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_halt_cancel();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_BR));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL halt_cancel[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_step();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    t.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    repeat (3) begin
      repeat (4) t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_HOLD));
      t.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, C_RUN));
    end
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_HOLD));
    t.push_back(mk(1, 0, 1, 1, 0, 5, 5, 1, 0, 0, C_STALL));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_HOLD));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_HOLD));
    t.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, C_STALL));
    t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_STALL));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL step[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 0, 0, 0, 0, 5, 5, 1, 1, 1, C_IDLE));
    t.push_back(mk(1, 0, 0, 0, 0, 5, 5, 1, 1, 1, C_IDLE));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl || cycle_count !== e.cnt) begin
        errors++;
        $display("FAIL reset_mid[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 i, obs, cycle_count, e.ctl, e.cnt);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    step_mode   = 1'b0;
    step        = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    ex_rt       = '0;
    ex_mem_read = 1'b0;
    br_taken    = 1'b0;
    halt        = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_halt();
    test_halt_cancel();
    test_step();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
